// File: rtl/sp_types_pkg.sv
// Shared widths, request/response layouts and encodings for the bank scratchpad controller.
package sp_types_pkg;

  localparam int unsigned BITS_PER_ROW = 32;
  localparam int unsigned MAT_S_W      = 2;
  localparam int unsigned ROW_S_W      = 6;
  localparam int unsigned WORD_W       = 16;

  localparam int unsigned SRAM_AW = MAT_S_W + ROW_S_W;
  localparam int unsigned WREQ_W  = BITS_PER_ROW + MAT_S_W + ROW_S_W + 1;
  localparam int unsigned RREQ_W  = WORD_W + MAT_S_W + ROW_S_W + 2;
  localparam int unsigned RSP_W   = 2 + WORD_W + BITS_PER_ROW;

  typedef enum logic [1:0] {
    OP_STORE = 2'b00,
    OP_GEMM  = 2'b01
  } rd_op_t;

  typedef struct packed {
    logic                    last;
    logic [MAT_S_W-1:0]      mat;
    logic [ROW_S_W-1:0]      row;
    logic [BITS_PER_ROW-1:0] data;
  } wreq_t;

  // op kept as raw bits so reserved encodings survive until they are dropped
  typedef struct packed {
    logic [1:0]         op;
    logic [MAT_S_W-1:0] mat;
    logic [ROW_S_W-1:0] row;
    logic [WORD_W-1:0]  addr;
  } rreq_t;

  typedef struct packed {
    logic [1:0]              op;
    logic [WORD_W-1:0]       addr;
    logic [BITS_PER_ROW-1:0] data;
  } rsp_t;

  typedef enum logic [1:0] {StIdle, StWr, StRd} cmd_state_e;

  typedef enum logic {GrantW, GrantR} grant_e;

  function automatic logic op_is_legal(logic [1:0] op);
    return (op == OP_STORE) || (op == OP_GEMM);
  endfunction

endpackage

// File: rtl/sp_bank_ctrl_if.sv
// FIFO, SRAM and response-FIFO signals of one bank controller.
interface sp_bank_ctrl_if;
  import sp_types_pkg::*;

  logic [WREQ_W-1:0]       wFIFO_rdata;
  logic                    wFIFO_empty;
  logic                    wFIFO_REN;
  logic [RREQ_W-1:0]       rFIFO_rdata;
  logic                    rFIFO_empty;
  logic                    rFIFO_REN;
  logic                    sram_en;
  logic                    sram_wen;
  logic [SRAM_AW-1:0]      sram_addr;
  logic [BITS_PER_ROW-1:0] sram_wdata;
  logic [BITS_PER_ROW-1:0] sram_rdata;
  logic [RSP_W-1:0]        rspFIFO_wdata;
  logic                    rspFIFO_WEN;
  logic                    rspFIFO_full;
  logic                    mat_done;
  logic [MAT_S_W-1:0]      mat_done_id;
  logic                    bad_op;

  modport master (
    input  wFIFO_rdata, wFIFO_empty, rFIFO_rdata, rFIFO_empty, sram_rdata, rspFIFO_full,
    output wFIFO_REN, rFIFO_REN, sram_en, sram_wen, sram_addr, sram_wdata,
    output rspFIFO_wdata, rspFIFO_WEN, mat_done, mat_done_id, bad_op
  );

  modport slave (
    output wFIFO_rdata, wFIFO_empty, rFIFO_rdata, rFIFO_empty, sram_rdata, rspFIFO_full,
    input  wFIFO_REN, rFIFO_REN, sram_en, sram_wen, sram_addr, sram_wdata,
    input  rspFIFO_wdata, rspFIFO_WEN, mat_done, mat_done_id, bad_op
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; any depth >= 2.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wen_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       ren_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_wr, do_rd;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_wr   = wen_i && !full_o;
  assign do_rd   = ren_i && !empty_o;
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_wr) wptr_q <= ptr_inc(wptr_q);
      if (do_rd) rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + CntW'(do_wr) - CntW'(do_rd);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sp_bank_ctrl.sv
// One bank: arbitrates the write and read-request FIFOs onto a single-port SRAM and
// returns read data through a skid buffer into the response FIFO.
module sp_bank_ctrl
  import sp_types_pkg::*;
#(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned SKID_D = RD_LAT + 1
) (
  input logic           clk,
  input logic           rst,
  sp_bank_ctrl_if.master bank_io
);

  localparam int unsigned SkidCntW = $clog2(SKID_D + 1);

  wreq_t      w_req;
  rreq_t      r_req;
  logic       r_legal, w_elig, r_elig, grant_w, grant_r, rsp_wen;
  logic [7:0] pipe_cnt, occ;

  cmd_state_e              state_q;
  grant_e                  last_grant_q;
  logic                    sram_en_q, sram_wen_q, cmd_last_q, mat_done_q, bad_op_q;
  logic [SRAM_AW-1:0]      sram_addr_q;
  logic [BITS_PER_ROW-1:0] sram_wdata_q;
  logic [1:0]              cmd_op_q;
  logic [WORD_W-1:0]       cmd_addr_q;
  logic [MAT_S_W-1:0]      mat_done_id_q;

  logic              pipe_v_q    [RD_LAT];
  logic [1:0]        pipe_op_q   [RD_LAT];
  logic [WORD_W-1:0] pipe_addr_q [RD_LAT];

  rsp_t                skid_wdata, skid_rdata;
  logic                skid_full, skid_empty;
  logic [SkidCntW-1:0] skid_cnt;

  assign w_req   = wreq_t'(bank_io.wFIFO_rdata);
  assign r_req   = rreq_t'(bank_io.rFIFO_rdata);
  assign r_legal = op_is_legal(r_req.op);

  // Reads still owed a skid slot: command on the bus, pipe stages, and skid entries not
  // leaving this cycle.
  always_comb begin
    pipe_cnt = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) pipe_cnt = pipe_cnt + 8'(pipe_v_q[i]);
    occ = 8'(skid_cnt) + pipe_cnt + 8'(state_q == StRd) - 8'(rsp_wen);
  end

  assign w_elig  = !bank_io.wFIFO_empty;
  assign r_elig  = !bank_io.rFIFO_empty && (!r_legal || (occ < 8'(SKID_D)));
  assign grant_w = !rst && w_elig && (!r_elig || (last_grant_q == GrantR));
  assign grant_r = !rst && r_elig && !grant_w;

  assign bank_io.wFIFO_REN = grant_w;
  assign bank_io.rFIFO_REN = grant_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      last_grant_q  <= GrantR;
      sram_en_q     <= 1'b0;
      sram_wen_q    <= 1'b0;
      sram_addr_q   <= '0;
      sram_wdata_q  <= '0;
      cmd_op_q      <= '0;
      cmd_addr_q    <= '0;
      cmd_last_q    <= 1'b0;
      mat_done_q    <= 1'b0;
      mat_done_id_q <= '0;
      bad_op_q      <= 1'b0;
    end else begin
      mat_done_q <= (state_q == StWr) && cmd_last_q;
      if ((state_q == StWr) && cmd_last_q) mat_done_id_q <= sram_addr_q[SRAM_AW-1 -: MAT_S_W];
      bad_op_q   <= grant_r && !r_legal;
      cmd_last_q <= 1'b0;
      if (grant_w) begin
        state_q      <= StWr;
        last_grant_q <= GrantW;
        sram_en_q    <= 1'b1;
        sram_wen_q   <= 1'b1;
        sram_addr_q  <= {w_req.mat, w_req.row};
        sram_wdata_q <= w_req.data;
        cmd_last_q   <= w_req.last;
      end else if (grant_r && r_legal) begin
        state_q      <= StRd;
        last_grant_q <= GrantR;
        sram_en_q    <= 1'b1;
        sram_wen_q   <= 1'b0;
        sram_addr_q  <= {r_req.mat, r_req.row};
        sram_wdata_q <= '0;
        cmd_op_q     <= r_req.op;
        cmd_addr_q   <= r_req.addr;
      end else begin
        // A dropped reserved op still counts as the read side's turn.
        state_q    <= StIdle;
        sram_en_q  <= 1'b0;
        sram_wen_q <= 1'b0;
        if (grant_r) last_grant_q <= GrantR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_v_q[i] <= 1'b0;
    end else begin
      pipe_v_q[0]    <= (state_q == StRd);
      pipe_op_q[0]   <= cmd_op_q;
      pipe_addr_q[0] <= cmd_addr_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_v_q[i]    <= pipe_v_q[i-1];
        pipe_op_q[i]   <= pipe_op_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
    end
  end

  assign skid_wdata = '{op: pipe_op_q[RD_LAT-1], addr: pipe_addr_q[RD_LAT-1],
                        data: bank_io.sram_rdata};
  assign rsp_wen    = !skid_empty && !bank_io.rspFIFO_full;

  sync_fifo #(
    .Width(RSP_W),
    .Depth(SKID_D)
  ) u_skid (
    .clk_i  (clk),
    .rst_i  (rst),
    .wen_i  (pipe_v_q[RD_LAT-1]),
    .wdata_i(skid_wdata),
    .ren_i  (rsp_wen),
    .rdata_o(skid_rdata),
    .full_o (skid_full),
    .empty_o(skid_empty),
    .count_o(skid_cnt)
  );

  skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(skid_full && pipe_v_q[RD_LAT-1]));

  assign bank_io.sram_en       = sram_en_q;
  assign bank_io.sram_wen      = sram_wen_q;
  assign bank_io.sram_addr     = sram_addr_q;
  assign bank_io.sram_wdata    = sram_wdata_q;
  assign bank_io.rspFIFO_WEN   = rsp_wen;
  assign bank_io.rspFIFO_wdata = skid_empty ? '0 : skid_rdata;
  assign bank_io.mat_done      = mat_done_q;
  assign bank_io.mat_done_id   = mat_done_id_q;
  assign bank_io.bad_op        = bad_op_q;

endmodule

// File: tb/tb_sp_bank_ctrl.sv
// Directed bench for sp_bank_ctrl: FIFO and SRAM models plus hand-computed expectations.
module tb_sp_bank_ctrl;
  import sp_types_pkg::*;

  localparam int unsigned RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sp_bank_ctrl_if bus_if ();

  sp_bank_ctrl #(
    .RD_LAT(RD_LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bank_io(bus_if)
  );

  wreq_t       wq[$];
  rreq_t       rq[$];
  rsp_t        rsp_q[$];
  rsp_t        exp_q[$];
  logic [31:0] ref_mem [256];
  logic [31:0] mem [256];
  logic [31:0] rd_pipe [RD_LAT];
  int          n_checks = 0;
  int          n_pass = 0;
  logic        fm_w_pop, fm_r_pop;
  logic        sm_en, sm_wen;
  logic [7:0]  sm_addr;
  logic [31:0] sm_wdata;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_fifos();
    bus_if.wFIFO_empty = (wq.size() == 0);
    bus_if.wFIFO_rdata = (wq.size() != 0) ? wq[0] : '0;
    bus_if.rFIFO_empty = (rq.size() == 0);
    bus_if.rFIFO_rdata = (rq.size() != 0) ? rq[0] : '0;
  endtask

  // First-word-fall-through FIFOs: pop what the DUT requested in the cycle just ended.
  always begin
    drive_fifos();
    @(posedge clk);
    fm_w_pop = bus_if.wFIFO_REN;
    fm_r_pop = bus_if.rFIFO_REN;
    #1;
    if (fm_w_pop && wq.size() != 0) void'(wq.pop_front());
    if (fm_r_pop && rq.size() != 0) void'(rq.pop_front());
    drive_fifos();
    @(negedge clk);
    #1;
  end

  // SRAM with RD_LAT cycles from command to data.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    for (int i = 0; i < int'(RD_LAT); i++) rd_pipe[i] = '0;
    bus_if.sram_rdata = '0;
    forever begin
      @(posedge clk);
      sm_en    = bus_if.sram_en;
      sm_wen   = bus_if.sram_wen;
      sm_addr  = bus_if.sram_addr;
      sm_wdata = bus_if.sram_wdata;
      #1;
      for (int i = int'(RD_LAT) - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
      rd_pipe[0] = (sm_en && !sm_wen) ? mem[sm_addr] : 32'hDEAD_BEEF;
      if (sm_en && sm_wen) mem[sm_addr] = sm_wdata;
      bus_if.sram_rdata = rd_pipe[RD_LAT-1];
    end
  end

  always @(posedge clk) begin
    if (bus_if.rspFIFO_WEN) rsp_q.push_back(rsp_t'(bus_if.rspFIFO_wdata));
  end

  task automatic push_w(input logic last, input logic [1:0] mat, input logic [5:0] row,
                        input logic [31:0] data);
    wq.push_back('{last: last, mat: mat, row: row, data: data});
    ref_mem[{mat, row}] = data;
  endtask

  task automatic push_r(input logic [1:0] op, input logic [1:0] mat, input logic [5:0] row,
                        input logic [15:0] addr);
    rq.push_back('{op: op, mat: mat, row: row, addr: addr});
    if (op[1] == 1'b0) exp_q.push_back('{op: op, addr: addr, data: ref_mem[{mat, row}]});
  endtask

  task automatic check_rsps(input string tag, input int n, input int budget);
    int waited = 0;
    while (rsp_q.size() < n && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, ".count"}, 64'(rsp_q.size()), 64'(n));
    for (int i = 0; i < rsp_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s.rsp%0d", tag, i), 64'(rsp_q[i]), 64'(exp_q[i]));
    rsp_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, ".wFIFO_REN"}, 64'(bus_if.wFIFO_REN), 64'd0);
    check_eq({tag, ".rFIFO_REN"}, 64'(bus_if.rFIFO_REN), 64'd0);
    check_eq({tag, ".sram_en"}, 64'(bus_if.sram_en), 64'd0);
    check_eq({tag, ".sram_wen"}, 64'(bus_if.sram_wen), 64'd0);
    check_eq({tag, ".rsp_wen"}, 64'(bus_if.rspFIFO_WEN), 64'd0);
    check_eq({tag, ".mat_done"}, 64'(bus_if.mat_done), 64'd0);
    check_eq({tag, ".bad_op"}, 64'(bus_if.bad_op), 64'd0);
    check_eq({tag, ".sram_addr"}, 64'(bus_if.sram_addr), 64'd0);
    check_eq({tag, ".sram_wdata"}, 64'(bus_if.sram_wdata), 64'd0);
    check_eq({tag, ".rsp_wdata"}, 64'(bus_if.rspFIFO_wdata), 64'd0);
    check_eq({tag, ".mat_done_id"}, 64'(bus_if.mat_done_id), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_rd;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h1000_0000 + i;
    bus_if.rspFIFO_full = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b0;

    // Single write with last=1.
    @(negedge clk);
    push_w(1'b1, 2'd2, 6'd5, 32'hA5A5_A5A5);
    #2;
    check_eq("wr.ren", 64'(bus_if.wFIFO_REN), 64'd1);
    @(negedge clk);
    check_eq("wr.sram_en", 64'(bus_if.sram_en), 64'd1);
    check_eq("wr.sram_wen", 64'(bus_if.sram_wen), 64'd1);
    check_eq("wr.sram_addr", 64'(bus_if.sram_addr), 64'h85);
    check_eq("wr.sram_wdata", 64'(bus_if.sram_wdata), 64'hA5A5_A5A5);
    @(negedge clk);
    check_eq("wr.mat_done", 64'(bus_if.mat_done), 64'd1);
    check_eq("wr.mat_done_id", 64'(bus_if.mat_done_id), 64'd2);
    check_eq("wr.sram_en_after", 64'(bus_if.sram_en), 64'd0);
    @(negedge clk);
    check_eq("wr.mat_done_pulse", 64'(bus_if.mat_done), 64'd0);

    // Read back the same row: response 4 cycles after the pop.
    push_r(2'b01, 2'd2, 6'd5, 16'h0100);
    #2;
    check_eq("rd.ren", 64'(bus_if.rFIFO_REN), 64'd1);
    @(negedge clk);
    check_eq("rd.sram_en", 64'(bus_if.sram_en), 64'd1);
    check_eq("rd.sram_wen", 64'(bus_if.sram_wen), 64'd0);
    check_eq("rd.sram_addr", 64'(bus_if.sram_addr), 64'h85);
    @(negedge clk);
    @(negedge clk);
    check_eq("rd.wen_early", 64'(bus_if.rspFIFO_WEN), 64'd0);
    @(negedge clk);
    check_eq("rd.wen", 64'(bus_if.rspFIFO_WEN), 64'd1);
    check_eq("rd.wdata", 64'(bus_if.rspFIFO_wdata), {14'd0, 2'b01, 16'h0100, 32'hA5A5_A5A5});
    check_rsps("rd", 1, 10);

    // Four writes and four reads queued together: strict W/R alternation.
    @(negedge clk);
    for (int k = 0; k < 4; k++) push_w(1'b0, 2'd1, 6'(k), 32'h5000_0000 + k);
    for (int k = 0; k < 4; k++) push_r(2'(k % 2), 2'd1, 6'(k), 16'h0200 + 16'(k));
    #2;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq($sformatf("alt.en%0d", k), 64'(bus_if.sram_en), 64'd1);
      check_eq($sformatf("alt.wen%0d", k), 64'(bus_if.sram_wen), 64'((k % 2) == 0));
    end
    check_rsps("alt", 4, 30);

    // Backpressure: only SKID_D reads may issue while the response FIFO is full.
    @(negedge clk);
    bus_if.rspFIFO_full = 1'b1;
    for (int k = 0; k < 10; k++) push_r(2'(k % 2), 2'd1, 6'(k), 16'h0300 + 16'(k));
    n_rd = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.sram_en && !bus_if.sram_wen) n_rd++;
    end
    check_eq("bp.reads_issued", 64'(n_rd), 64'd3);
    check_eq("bp.rfifo_left", 64'(rq.size()), 64'd7);
    check_eq("bp.no_rsp", 64'(rsp_q.size()), 64'd0);
    bus_if.rspFIFO_full = 1'b0;
    check_rsps("bp", 10, 80);

    // Reserved op is popped and dropped.
    @(negedge clk);
    push_r(2'b11, 2'd0, 6'd0, 16'h0BAD);
    #2;
    check_eq("bad.ren", 64'(bus_if.rFIFO_REN), 64'd1);
    @(negedge clk);
    check_eq("bad.pulse", 64'(bus_if.bad_op), 64'd1);
    check_eq("bad.sram_en", 64'(bus_if.sram_en), 64'd0);
    @(negedge clk);
    check_eq("bad.pulse_end", 64'(bus_if.bad_op), 64'd0);
    repeat (8) @(negedge clk);
    check_rsps("bad", 0, 0);

    // Reset while two reads are in flight discards them.
    push_r(2'b00, 2'd1, 6'd0, 16'h0400);
    push_r(2'b01, 2'd1, 6'd1, 16'h0401);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst.rd2_on_bus", 64'(bus_if.sram_en && !bus_if.sram_wen), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outs("rst_mid");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("rst.no_rsp", 64'(rsp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
